max_pool_stream: RTL and testbench



---
 rtl/cnn_pkg.sv | 13 +
 rtl/pool_row_buffer.sv | 27 ++
 rtl/max_pool_stream.sv | 164 ++++++++++++++++
 tb/tb_max_pool_stream.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN datapath types and geometry constants.
package cnn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } pool_state_e;

  localparam int CNN_IMG_W  = 28;
  localparam int CONV_OUT_W = CNN_IMG_W - 2;

endpackage

// File: rtl/pool_row_buffer.sv
// Half-width row buffer holding the horizontal pair maxima of an even row.
// One synchronous write port, one combinational read port; no reset on contents.
module pool_row_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 13,
  parameter int ADDR_W     = 4
) (
  input  logic                         clk_i,
  input  logic                         wr_en_i,
  input  logic [ADDR_W-1:0]            wr_addr_i,
  input  logic signed [DATA_WIDTH-1:0] wr_data_i,
  input  logic [ADDR_W-1:0]            rd_addr_i,
  output logic signed [DATA_WIDTH-1:0] rd_data_o
);

  logic signed [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i && (int'(wr_addr_i) < DEPTH)) begin
      r_mem[wr_addr_i] <= wr_data_i;
    end
  end

  // Addresses past DEPTH only occur for the discarded trailing column.
  assign rd_data_o = (int'(rd_addr_i) < DEPTH) ? r_mem[rd_addr_i] : '0;

endmodule

// File: rtl/max_pool_stream.sv
// Streaming 2x2/stride-2 signed max pool; one output register, result valid the cycle after the odd-row/odd-col input.
// Input stalls (in_ready_o low) whenever the output register is full and not being drained.
module max_pool_stream
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_W      = CONV_OUT_W,
  parameter int IMG_H      = CONV_OUT_W
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic signed [DATA_WIDTH-1:0] in_data_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  output logic signed [DATA_WIDTH-1:0] out_data_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic                         out_last_o,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int POOL_W = IMG_W / 2;
  localparam int POOL_H = IMG_H / 2;
  localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int BUF_AW = (POOL_W > 1) ? $clog2(POOL_W) : 1;

  localparam logic [COL_W-1:0] COL_LAST      = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_PAIR_LAST = COL_W'(POOL_W - 1);
  localparam logic [ROW_W-1:0] ROW_PAIR_LAST = ROW_W'(POOL_H - 1);

  pool_state_e                  r_state;
  logic [COL_W-1:0]             r_col;
  logic [ROW_W-1:0]             r_row;
  logic signed [DATA_WIDTH-1:0] r_hold;
  logic signed [DATA_WIDTH-1:0] r_out_data;
  logic                         r_out_valid;
  logic                         r_out_last;
  logic                         r_busy;
  logic                         r_done;

  logic                         w_out_free;
  logic                         w_in_hs;
  logic                         w_col_last;
  logic                         w_row_last;
  logic                         w_frame_last;
  logic [COL_W-1:0]             w_col_pair;
  logic [ROW_W-1:0]             w_row_pair;
  logic [BUF_AW-1:0]            w_buf_addr;
  logic                         w_buf_we;
  logic                         w_out_load;
  logic                         w_last_pair;
  logic signed [DATA_WIDTH-1:0] w_buf_rd;
  logic signed [DATA_WIDTH-1:0] w_max_hx;
  logic signed [DATA_WIDTH-1:0] w_max_all;

  assign w_out_free   = !r_out_valid || out_ready_i;
  assign in_ready_o   = (r_state == RUN) && w_out_free;
  assign w_in_hs      = in_valid_i && in_ready_o;

  assign w_col_last   = (r_col == COL_LAST);
  assign w_row_last   = (r_row == ROW_LAST);
  assign w_frame_last = w_col_last && w_row_last;

  assign w_col_pair   = r_col >> 1;
  assign w_row_pair   = r_row >> 1;
  assign w_buf_addr   = BUF_AW'(w_col_pair);

  // Trailing odd column/row never reach an odd-col load, so they fall out naturally.
  assign w_buf_we     = w_in_hs && r_col[0] && !r_row[0];
  assign w_out_load   = w_in_hs && r_col[0] && r_row[0];
  assign w_last_pair  = (w_col_pair == COL_PAIR_LAST) && (w_row_pair == ROW_PAIR_LAST);

  assign w_max_hx     = (r_hold > in_data_i) ? r_hold : in_data_i;
  assign w_max_all    = (w_buf_rd > w_max_hx) ? w_buf_rd : w_max_hx;

  pool_row_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (POOL_W),
    .ADDR_W     (BUF_AW)
  ) u_row_buf (
    .clk_i      (clk_i),
    .wr_en_i    (w_buf_we),
    .wr_addr_i  (w_buf_addr),
    .wr_data_i  (w_max_hx),
    .rd_addr_i  (w_buf_addr),
    .rd_data_o  (w_buf_rd)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_hold      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;

      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_col   <= '0;
            r_row   <= '0;
            r_state <= RUN;
            r_busy  <= 1'b1;
          end
        end
        RUN: begin
          if (w_in_hs && w_frame_last) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_out_free) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      if (w_in_hs) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
        if (!r_col[0]) begin
          r_hold <= in_data_i;
        end
      end

      // A fresh load wins over a concurrent drain so valid stays high back-to-back.
      if (w_out_load) begin
        r_out_data  <= w_max_all;
        r_out_valid <= 1'b1;
        r_out_last  <= w_last_pair;
      end else if (out_ready_i) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign out_data_o  = r_out_data;
  assign out_valid_o = r_out_valid;
  assign out_last_o  = r_out_last;
  assign busy_o      = r_busy;
  assign done_o      = r_done;

endmodule

// File: tb/tb_max_pool_stream.sv
// Directed bench for max_pool_stream: a 4x4 instance and a 5x5 instance, scoreboard-checked.
module tb_max_pool_stream;

  typedef struct {
    logic signed [31:0] d;
    logic               l;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  logic               a_start, a_vin, a_rin, a_vout, a_rout, a_last, a_busy, a_done;
  logic signed [31:0] a_din, a_dout;
  logic               b_start, b_vin, b_rin, b_vout, b_rout, b_last, b_busy, b_done;
  logic signed [31:0] b_din, b_dout;

  exp_t qa[$];
  exp_t qb[$];
  exp_t m_e;
  int   errors = 0;
  int   checks = 0;
  int   a_dones = 0;
  int   b_dones = 0;

  always #5 clk = ~clk;

  max_pool_stream #(.DATA_WIDTH(32), .IMG_W(4), .IMG_H(4)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(a_start),
    .in_data_i(a_din), .in_valid_i(a_vin), .in_ready_o(a_rin),
    .out_data_o(a_dout), .out_valid_o(a_vout), .out_ready_i(a_rout),
    .out_last_o(a_last), .busy_o(a_busy), .done_o(a_done)
  );

  max_pool_stream #(.DATA_WIDTH(32), .IMG_W(5), .IMG_H(5)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(b_start),
    .in_data_i(b_din), .in_valid_i(b_vin), .in_ready_o(b_rin),
    .out_data_o(b_dout), .out_valid_o(b_vout), .out_ready_i(b_rout),
    .out_last_o(b_last), .busy_o(b_busy), .done_o(b_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference 2x2 pooling of a raster frame whose sample i is base+step*i.
  task automatic push_exp(input int sel, input int w, input int h, input int base, input int step);
    exp_t e;
    int   m;
    int   v;
    for (int pr = 0; pr < h / 2; pr++) begin
      for (int pc = 0; pc < w / 2; pc++) begin
        m = base + step * ((2 * pr) * w + 2 * pc);
        for (int dr = 0; dr < 2; dr++) begin
          for (int dc = 0; dc < 2; dc++) begin
            v = base + step * ((2 * pr + dr) * w + 2 * pc + dc);
            if (v > m) m = v;
          end
        end
        e.d = m;
        e.l = (pr == h / 2 - 1) && (pc == w / 2 - 1);
        if (sel != 0) qb.push_back(e);
        else          qa.push_back(e);
      end
    end
  endtask

  task automatic set_drv(input int sel, input logic vld, input logic signed [31:0] dat, input logic st);
    if (sel != 0) begin b_vin = vld; b_din = dat; b_start = st; end
    else          begin a_vin = vld; a_din = dat; a_start = st; end
  endtask

  task automatic start_frame(input int sel, input string tag);
    set_drv(sel, 1'b0, 32'sd0, 1'b1);
    @(negedge clk);
    chk({tag, "_busy_before"}, 64'((sel != 0) ? b_busy : a_busy), 64'd0);
    @(posedge clk); #1;
    set_drv(sel, 1'b0, 32'sd0, 1'b0);
    @(negedge clk);
    chk({tag, "_busy_after"}, 64'((sel != 0) ? b_busy : a_busy), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic send(input int sel, input int n, input int base, input int step,
                      input int start_idx, input bit start_end, output int acc);
    int t;
    bit ok;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      set_drv(sel, 1'b1, base + step * i, (i == start_idx));
      t = 0;
      ok = 1'b0;
      while (!ok && t < 200) begin
        @(negedge clk);
        ok = (sel != 0) ? b_rin : a_rin;
        @(posedge clk); #1;
        set_drv(sel, 1'b1, base + step * i, 1'b0);
        t++;
      end
      if (!ok) begin
        chk("send_timeout", 64'(i), 64'(-1));
        break;
      end
      acc++;
    end
    set_drv(sel, 1'b0, 32'sd0, 1'b0);
    if (start_end) begin
      set_drv(sel, 1'b0, 32'sd0, 1'b1);
      @(posedge clk); #1;
      set_drv(sel, 1'b0, 32'sd0, 1'b0);
    end
  endtask

  task automatic wait_idle(input int sel, input int dones_exp, input string tag);
    int t;
    t = 0;
    while (t < 200 && !(((sel != 0) ? qb.size() : qa.size()) == 0 &&
                        ((sel != 0) ? b_dones : a_dones) == dones_exp &&
                        !((sel != 0) ? b_busy : a_busy))) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (5) begin @(posedge clk); #1; end
    chk({tag, "_done_cnt"}, 64'((sel != 0) ? b_dones : a_dones), 64'(dones_exp));
    chk({tag, "_pending"}, 64'((sel != 0) ? qb.size() : qa.size()), 64'd0);
    chk({tag, "_busy_idle"}, 64'((sel != 0) ? b_busy : a_busy), 64'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (a_done) a_dones++;
      if (b_done) b_dones++;
      if (a_vout && a_rout) begin
        checks++;
        assert (qa.size() > 0) else begin
          errors++;
          $error("FAIL a_extra_out observed=%0d expected=no output", a_dout);
        end
        if (qa.size() > 0) begin
          m_e = qa.pop_front();
          chk("a_out_data", 64'(a_dout), 64'(m_e.d));
          chk("a_out_last", 64'(a_last), 64'(m_e.l));
        end
      end
      if (b_vout && b_rout) begin
        checks++;
        assert (qb.size() > 0) else begin
          errors++;
          $error("FAIL b_extra_out observed=%0d expected=no output", b_dout);
        end
        if (qb.size() > 0) begin
          m_e = qb.pop_front();
          chk("b_out_data", 64'(b_dout), 64'(m_e.d));
          chk("b_out_last", 64'(b_last), 64'(m_e.l));
        end
      end
    end
  end

  initial begin
    int acc;
    int acc_bp;
    int t;
    rst_n = 1'b0;
    set_drv(0, 1'b0, 32'sd0, 1'b0);
    set_drv(1, 1'b0, 32'sd0, 1'b0);
    a_rout = 1'b1;
    b_rout = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_outs", 64'({a_rin, a_vout, a_last, a_busy, a_done}), 64'd0);
    chk("rst_a_data", 64'(a_dout), 64'd0);
    chk("rst_b_outs", 64'({b_rin, b_vout, b_last, b_busy, b_done}), 64'd0);
    chk("rst_b_data", 64'(b_dout), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Input offered while idle must not be taken.
    set_drv(0, 1'b1, 32'sd99, 1'b0);
    @(negedge clk);
    chk("idle_in_ready", 64'(a_rin), 64'd0);
    @(posedge clk); #1;
    set_drv(0, 1'b0, 32'sd0, 1'b0);

    // Clean 4x4 frame: 5,7,13,15.
    push_exp(0, 4, 4, 0, 1);
    start_frame(0, "clean");
    send(0, 16, 0, 1, -1, 1'b0, acc);
    chk("clean_accepted", 64'(acc), 64'd16);
    wait_idle(0, 1, "clean");

    // Signed: -1..-16 -> -1,-3,-9,-11.
    push_exp(0, 4, 4, -1, -1);
    start_frame(0, "signed");
    send(0, 16, -1, -1, -1, 1'b0, acc);
    wait_idle(0, 2, "signed");

    // Backpressure: consumer stalls 5 cycles on the first result.
    push_exp(0, 4, 4, 0, 1);
    a_rout = 1'b0;
    start_frame(0, "bp");
    fork
      begin
        send(0, 16, 0, 1, -1, 1'b0, acc_bp);
      end
      begin
        t = 0;
        @(negedge clk);
        while (!a_vout && t < 100) begin
          @(negedge clk);
          t++;
        end
        chk("bp_valid_seen", 64'(a_vout), 64'd1);
        for (int k = 0; k < 5; k++) begin
          chk("bp_in_ready", 64'(a_rin), 64'd0);
          chk("bp_hold_data", 64'(a_dout), 64'd5);
          chk("bp_hold_valid", 64'(a_vout), 64'd1);
          if (k < 4) @(negedge clk);
        end
        @(posedge clk); #1;
        a_rout = 1'b1;
      end
    join
    chk("bp_accepted", 64'(acc_bp), 64'd16);
    wait_idle(0, 3, "bp");

    // Odd 5x5 frame: 6,8,16,18; all 25 taken, done only after the last one.
    push_exp(1, 5, 5, 0, 1);
    start_frame(1, "odd");
    send(1, 25, 0, 1, -1, 1'b0, acc);
    chk("odd_accepted", 64'(acc), 64'd25);
    chk("odd_no_early_done", 64'(b_dones), 64'd0);
    wait_idle(1, 1, "odd");

    // Reset mid-frame with a result parked in the output register.
    a_rout = 1'b0;
    start_frame(0, "mid");
    send(0, 6, 0, 1, -1, 1'b0, acc);
    @(negedge clk);
    chk("mid_parked_valid", 64'(a_vout), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_outs", 64'({a_rin, a_vout, a_last, a_busy, a_done}), 64'd0);
    chk("mid_rst_data", 64'(a_dout), 64'd0);
    @(posedge clk); #1;
    a_rout = 1'b1;
    push_exp(0, 4, 4, 0, 1);
    start_frame(0, "mid_restart");
    send(0, 16, 0, 1, -1, 1'b0, acc);
    wait_idle(0, 4, "mid_restart");

    // Start pulses during RUN (at input 7) and during DRAIN are ignored.
    push_exp(0, 4, 4, 0, 1);
    start_frame(0, "sbusy");
    send(0, 16, 0, 1, 7, 1'b1, acc);
    chk("sbusy_accepted", 64'(acc), 64'd16);
    wait_idle(0, 5, "sbusy");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
